// File: rtl/mpu_spi_arbiter.sv
// Round-robin arbiter sharing one MPU9250 SPI register-access engine between
// three requesters; sequences start/busy, returns read data and done/err pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | engine free; pick next requester from the rr pointer
// ISSUE     | one-cycle mpu_start pulse with latched fields
// WAIT_ACK  | waiting for the engine to raise busy (ACK_TIMEOUT bound)
// WAIT_DONE | engine busy; waiting for it to drop (DONE_TIMEOUT bound)
// RELEASE   | grant dropped, rr pointer advanced past the owner
module mpu_spi_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ACK_TIMEOUT  = 16,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]     req_rw,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic [7:0]             rd_data,
  output logic [6:0]             mpu_address,
  output logic [7:0]             mpu_wr_data,
  output logic                   mpu_rd_wr_sel,
  output logic                   mpu_start,
  input  logic                   mpu_busy,
  input  logic [7:0]             mpu_rd_data
);

  localparam logic [15:0] ACK_LIMIT  = 16'(ACK_TIMEOUT);
  localparam logic [15:0] DONE_LIMIT = 16'(DONE_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RELEASE
  } state_t;

  state_t state_q, state_d;

  logic [15:0]        cnt_q, cnt_d, cnt_inc;
  logic [1:0]         rr_q, rr_d;
  logic [NUM_REQ-1:0] grant_d, done_d, err_d;
  logic [7:0]         rd_data_d;
  logic [6:0]         addr_d;
  logic [7:0]         wdata_d;
  logic               sel_d;
  logic               start_d;

  logic               win_valid;
  logic [1:0]         win_idx;
  logic [6:0]         win_addr;
  logic [7:0]         win_wdata;
  logic               win_rw;
  logic [1:0]         rr_next;

  // First set request at or above the rr pointer, wrapping modulo 3.
  always_comb begin
    win_valid = |req;
    win_idx   = 2'd0;
    case (rr_q)
      2'd1:    win_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    win_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    win_addr  = req_addr[6:0];
    win_wdata = req_wdata[7:0];
    win_rw    = req_rw[0];
    case (win_idx)
      2'd1: begin
        win_addr  = req_addr[13:7];
        win_wdata = req_wdata[15:8];
        win_rw    = req_rw[1];
      end
      2'd2: begin
        win_addr  = req_addr[20:14];
        win_wdata = req_wdata[23:16];
        win_rw    = req_rw[2];
      end
      default: begin
        win_addr  = req_addr[6:0];
        win_wdata = req_wdata[7:0];
        win_rw    = req_rw[0];
      end
    endcase
  end

  // The grant vector identifies the owner, so the pointer advance is decoded from it.
  always_comb begin
    rr_next = 2'd0;
    if (grant[0]) rr_next = 2'd1;
    else if (grant[1]) rr_next = 2'd2;
  end

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    grant_d   = grant;
    done_d    = '0;
    err_d     = '0;
    rd_data_d = rd_data;
    addr_d    = mpu_address;
    wdata_d   = mpu_wr_data;
    sel_d     = mpu_rd_wr_sel;
    start_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mpu_busy && win_valid) begin
          grant_d = NUM_REQ'(1) << win_idx;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          sel_d   = win_rw;
          start_d = 1'b1;
          cnt_d   = 16'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = cnt_inc;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (mpu_busy) begin
          cnt_d   = 16'd0;
          state_d = WAIT_DONE;
        end else if (cnt_q >= ACK_LIMIT) begin
          err_d   = grant;
          done_d  = grant;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!mpu_busy) begin
          done_d = grant;
          if (mpu_rd_wr_sel) rd_data_d = mpu_rd_data;
          state_d = RELEASE;
        end else if (cnt_q >= DONE_LIMIT) begin
          err_d   = grant;
          done_d  = grant;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE: begin
        grant_d = '0;
        rr_d    = rr_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 16'd0;
      rr_q          <= 2'd0;
      grant         <= '0;
      done          <= '0;
      err           <= '0;
      rd_data       <= 8'd0;
      mpu_address   <= 7'd0;
      mpu_wr_data   <= 8'd0;
      mpu_rd_wr_sel <= 1'b1;
      mpu_start     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rr_q          <= rr_d;
      grant         <= grant_d;
      done          <= done_d;
      err           <= err_d;
      rd_data       <= rd_data_d;
      mpu_address   <= addr_d;
      mpu_wr_data   <= wdata_d;
      mpu_rd_wr_sel <= sel_d;
      mpu_start     <= start_d;
    end
  end

endmodule

// File: tb/tb_mpu_spi_arbiter.sv
// Directed bench for mpu_spi_arbiter with a simple SPI engine model and an
// expected-transaction queue checked at every done pulse.
module tb_mpu_spi_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [20:0] req_addr = '0;
  logic [23:0] req_wdata = '0;
  logic [2:0]  req_rw = '0;
  logic [2:0]  grant, done, err;
  logic [7:0]  rd_data;
  logic [6:0]  mpu_address;
  logic [7:0]  mpu_wr_data;
  logic        mpu_rd_wr_sel;
  logic        mpu_start;
  logic        mpu_busy = 1'b0;
  logic [7:0]  mpu_rd_data = 8'd0;

  mpu_spi_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rw(req_rw), .grant(grant), .done(done), .err(err), .rd_data(rd_data),
    .mpu_address(mpu_address), .mpu_wr_data(mpu_wr_data), .mpu_rd_wr_sel(mpu_rd_wr_sel),
    .mpu_start(mpu_start), .mpu_busy(mpu_busy), .mpu_rd_data(mpu_rd_data)
  );

  always #5 clk = ~clk;

  // Engine model: optional ack delay, busy for eng_len cycles, read data = addr + eng_off.
  int         eng_len = 4;
  int         eng_ack_dly = 0;
  bit         eng_hang = 1'b0;
  logic [7:0] eng_off = 8'd0;
  int         eng_busy_cnt = 0;
  int         eng_dly_cnt = 0;
  logic [6:0] eng_addr = '0;

  always @(negedge clk) begin
    if (eng_busy_cnt > 0) begin
      eng_busy_cnt = eng_busy_cnt - 1;
      if (eng_busy_cnt == 0) begin
        mpu_busy = 1'b0;
        mpu_rd_data = {1'b0, eng_addr} + eng_off;
      end
    end else if (eng_dly_cnt > 0) begin
      eng_dly_cnt = eng_dly_cnt - 1;
      if (eng_dly_cnt == 0) begin
        mpu_busy = 1'b1;
        eng_busy_cnt = eng_len;
      end
    end else if (mpu_start && !eng_hang) begin
      eng_addr = mpu_address;
      if (eng_ack_dly == 0) begin
        mpu_busy = 1'b1;
        eng_busy_cnt = eng_len;
      end else begin
        eng_dly_cnt = eng_ack_dly;
      end
    end
  end

  typedef struct {
    int         owner;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       rw;
    logic       err;
    logic [7:0] rdata;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  bit         multi_hot = 1'b0;
  logic [7:0] last_rd = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int owner, input logic [6:0] addr, input logic [7:0] wdata,
                          input logic rw, input logic e_err, input int lat);
    exp_t e;
    e.owner = owner;
    e.addr  = addr;
    e.wdata = wdata;
    e.rw    = rw;
    e.err   = e_err;
    e.lat   = lat;
    if (rw && !e_err) last_rd = {1'b0, addr} + eng_off;
    e.rdata = last_rd;
    sb.push_back(e);
  endtask

  // mod_kind: 0 none, 1 drop owner's req, 2 change owner's address; applied mod_at cycles after start.
  task automatic wait_txn(input int limit, input logic [2:0] drop_mask, input int mod_at, input int mod_kind);
    exp_t       e;
    int         starts, start_cyc, done_cyc, c, own;
    bit         seen;
    logic [6:0] s_addr;
    logic [7:0] s_wd;
    logic       s_sel;
    starts = 0; start_cyc = -1; done_cyc = 0; c = 0; seen = 1'b0;
    s_addr = '0; s_wd = '0; s_sel = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'(sb.size()), 32'd1);
      return;
    end
    own = sb[0].owner;
    while (!seen && c < limit) begin
      @(negedge clk);
      c++;
      if ($countones(grant) > 1 || $countones(done) > 1 || $countones(err) > 1) multi_hot = 1'b1;
      if (mpu_start) begin
        starts++;
        start_cyc = c;
        s_addr = mpu_address;
        s_wd = mpu_wr_data;
        s_sel = mpu_rd_wr_sel;
      end
      if (start_cyc >= 0 && c == start_cyc + mod_at) begin
        if (mod_kind == 1) req[own] = 1'b0;
        if (mod_kind == 2) req_addr[7*own +: 7] = 7'h3B;
      end
      if (done != 3'b000) begin
        seen = 1'b1;
        done_cyc = c;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      e = sb.pop_front();
      chk("done_owner", 32'(done), 32'(3'b001 << e.owner));
      chk("grant_owner", 32'(grant), 32'(3'b001 << e.owner));
      chk("err", 32'(err), e.err ? 32'(3'b001 << e.owner) : 32'd0);
      chk("start_count", 32'(starts), 32'd1);
      chk("start_addr", 32'(s_addr), 32'(e.addr));
      chk("start_sel", 32'(s_sel), 32'(e.rw));
      chk("held_addr", 32'(mpu_address), 32'(e.addr));
      if (!e.rw) chk("start_wdata", 32'(s_wd), 32'(e.wdata));
      chk("rd_data", 32'(rd_data), 32'(e.rdata));
      if (e.lat > 0) chk("latency", 32'(done_cyc - start_cyc), 32'(e.lat));
    end
    req = req & ~drop_mask;
    @(negedge clk);
    chk("done_cleared", 32'(done), 32'd0);
    chk("grant_cleared", 32'(grant), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_addr"}, 32'(mpu_address), 32'd0);
    chk({tag, "_wdata"}, 32'(mpu_wr_data), 32'd0);
    chk({tag, "_sel"}, 32'(mpu_rd_wr_sel), 32'd1);
    chk({tag, "_start"}, 32'(mpu_start), 32'd0);
  endtask

  initial begin
    int spurious;
    int c;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // single read from requester 0
    eng_len = 20; eng_off = 8'hFC;
    req_addr[6:0] = 7'h75; req_rw = 3'b001;
    push_exp(0, 7'h75, 8'h00, 1'b1, 1'b0, 0);
    req = 3'b001;
    wait_txn(200, 3'b001, 0, 0);

    // write from requester 2, rd_data must keep 8'h71
    eng_len = 5;
    req_addr[20:14] = 7'h6B; req_wdata[23:16] = 8'h00; req_rw[2] = 1'b0;
    push_exp(2, 7'h6B, 8'h00, 1'b0, 1'b0, 0);
    req = 3'b100;
    wait_txn(200, 3'b100, 0, 0);
    chk("write_keeps_rd", 32'(rd_data), 32'h71);

    // fairness: all held for six transactions
    eng_len = 3; eng_off = 8'h40;
    req_addr = {7'h03, 7'h02, 7'h01}; req_rw = 3'b111;
    for (int k = 0; k < 6; k++) push_exp(k % 3, 7'(k % 3 + 1), 8'h00, 1'b1, 1'b0, 0);
    req = 3'b111;
    for (int k = 0; k < 5; k++) wait_txn(200, 3'b000, 0, 0);
    wait_txn(200, 3'b111, 0, 0);

    // ack timeout on requester 0, then requester 1 served normally
    eng_hang = 1'b1;
    req_addr = {7'h00, 7'h06, 7'h05}; req_rw = 3'b011;
    push_exp(0, 7'h05, 8'h00, 1'b1, 1'b1, 17);
    push_exp(1, 7'h06, 8'h00, 1'b1, 1'b0, 0);
    req = 3'b011;
    wait_txn(100, 3'b001, 0, 0);
    eng_hang = 1'b0;
    wait_txn(200, 3'b010, 0, 0);

    // reset asserted during WAIT_DONE
    eng_len = 60;
    req_addr[6:0] = 7'h10; req_rw = 3'b001;
    req = 3'b001;
    c = 0;
    while (!(mpu_busy && grant != 3'b000) && c < 30) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    chk("midrst_owned", 32'(grant), 32'd1);
    reset = 1'b1;
    req = 3'b000;
    @(negedge clk);
    chk_reset_vals("midrst");
    reset = 1'b0;
    last_rd = 8'd0;
    spurious = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done != 3'b000 || err != 3'b000 || mpu_start) spurious++;
    end
    chk("midrst_no_done", 32'(spurious), 32'd0);

    // requester 1 drops req during WAIT_DONE; done still pulses
    eng_len = 10; eng_off = 8'h11;
    req_addr[13:7] = 7'h22; req_rw = 3'b010;
    push_exp(1, 7'h22, 8'h00, 1'b1, 1'b0, 0);
    req = 3'b010;
    wait_txn(200, 3'b010, 4, 1);

    // address changed during WAIT_ACK must not reach the engine
    eng_len = 4; eng_ack_dly = 6;
    req_addr[13:7] = 7'h1A;
    push_exp(1, 7'h1A, 8'h00, 1'b1, 1'b0, 0);
    req = 3'b010;
    wait_txn(200, 3'b010, 2, 2);
    eng_ack_dly = 0;

    chk("never_multi_hot", 32'(multi_hot), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
